// File: rtl/aes_ks_pkg.sv
// AES-128 key schedule shared types, constants and GF(2^8) helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_ks_pkg;

    localparam int         AES_NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT      = 8'h01;

    typedef logic [31:0] aes_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        STEP = 2'd2
    } ks_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of i_dat).
module aes_sbox
    import aes_ks_pkg::*;
(
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat
);

    // Shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse as a^254 via a square/multiply chain; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        return gf_mul(x127, x127);
    endfunction

    logic [7:0] w_inv;

    assign w_inv = gf_inv(i_dat);

    // Affine map: b = a ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
    assign o_dat = w_inv
                 ^ {w_inv[6:0], w_inv[7]}
                 ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]}
                 ^ {w_inv[3:0], w_inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/aes_key_sched_stream.sv
// Sequential AES-128 key schedule streaming round keys 0..10 on a valid/ready port.
// Latency: first key one cycle after ld; one key per two cycles with rk_ready held high.
// Backpressure: rk/rk_idx hold indefinitely while rk_ready=0; ld always wins. Optional: AES_KS_LAST_KEY_EN.
module aes_key_sched_stream
    import aes_ks_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,  // only 10 is meaningful for AES-128
    parameter int KEY_W      = 128              // datapath below assumes four 32-bit words
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] rk,
    output logic [3:0]       rk_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
`ifdef AES_KS_LAST_KEY_EN
    ,
    output logic [KEY_W-1:0] last_rk,
    output logic             last_rk_valid
`endif
);

    ks_state_e        r_state;
    ks_state_e        w_state_nxt;
    logic [KEY_W-1:0] r_rk;
    logic [3:0]       r_idx;
    logic [7:0]       r_rcon;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic             w_step;

    aes_word_t        w_w0, w_w1, w_w2, w_w3;
    aes_word_t        w_rot, w_sub, w_t;
    aes_word_t        w_n0, w_n1, w_n2, w_n3;

    // ld masks valid so a handshake is never seen in a cycle that ld overrides.
    assign rk_valid = (r_state == EMIT) && !ld;
    assign w_accept = rk_valid && rk_ready;
    assign w_last   = (r_idx == 4'(NUM_ROUNDS));

    assign rk     = r_rk;
    assign rk_idx = r_idx;
    assign busy   = (r_state != IDLE);
    assign done   = r_done;

    // Next round key: word0 is the most significant word.
    assign w_w0  = r_rk[127:96];
    assign w_w1  = r_rk[95:64];
    assign w_w2  = r_rk[63:32];
    assign w_w3  = r_rk[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_dat (w_rot[8*g +: 8]),
            .o_dat (w_sub[8*g +: 8])
        );
    end

    assign w_t  = w_sub ^ {r_rcon, 24'h0};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; a load restarts from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        if (ld) begin
            w_state_nxt = EMIT;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                EMIT:    if (w_accept) w_state_nxt = w_last ? IDLE : STEP;
                STEP: begin
                    w_step      = 1'b1;
                    w_state_nxt = EMIT;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Round-key datapath: load on ld, advance one round per STEP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rk   <= '0;
            r_idx  <= 4'd0;
            r_rcon <= RCON_INIT;
        end else if (ld) begin
            r_rk   <= key;
            r_idx  <= 4'd0;
            r_rcon <= RCON_INIT;
        end else if (w_step) begin
            r_rk   <= {w_n0, w_n1, w_n2, w_n3};
            r_idx  <= r_idx + 4'd1;
            r_rcon <= xtime(r_rcon);
        end
    end

    // done follows acceptance of the final key; a same-cycle ld suppresses the accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_done <= 1'b0;
        else      r_done <= w_accept && w_last;
    end

`ifdef AES_KS_LAST_KEY_EN
    logic [KEY_W-1:0] r_last_rk;
    logic             r_last_vld;

    // Keep the final round key so a decrypt pass can start without re-expansion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_rk  <= '0;
            r_last_vld <= 1'b0;
        end else if (ld) begin
            r_last_vld <= 1'b0;
        end else if (w_accept && w_last) begin
            r_last_rk  <= r_rk;
            r_last_vld <= 1'b1;
        end
    end

    assign last_rk       = r_last_rk;
    assign last_rk_valid = r_last_vld;
`endif

endmodule

// File: tb/tb_aes_key_sched_stream.sv
// Directed bench for the AES-128 streaming key schedule (FIPS-197 and all-zero keys).
// Inputs change on the falling edge, outputs are sampled 1 ns later.
// Build with AES_KS_LAST_KEY_EN defined to exercise the last-key outputs.
module tb_aes_key_sched_stream;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] ZK_RK1   = 128'h62636363_62636363_62636363_62636363;
    localparam logic [127:0] ZK_RK2   = 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld;
    logic [127:0] key;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;
`ifdef AES_KS_LAST_KEY_EN
    logic [127:0] last_rk;
    logic         last_rk_valid;
`endif

    int checks   = 0;
    int failures = 0;

    logic [127:0] fips_rk [0:10];

    always #5 clk = ~clk;

    aes_key_sched_stream dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .key      (key),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
`ifdef AES_KS_LAST_KEY_EN
        ,
        .last_rk       (last_rk),
        .last_rk_valid (last_rk_valid)
`endif
    );

    task automatic test_reset();
        rst = 1'b0; ld = 1'b0; key = '0; rk_ready = 1'b0;
        #3;
        checks++; if (rk !== 128'h0)      begin failures++; $display("FAIL reset_rk got=%h exp=0", rk); end
        checks++; if (rk_idx !== 4'd0)    begin failures++; $display("FAIL reset_idx got=%0d exp=0", rk_idx); end
        checks++; if (rk_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", rk_valid); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
`ifdef AES_KS_LAST_KEY_EN
        checks++; if (last_rk !== 128'h0 || last_rk_valid !== 1'b0) begin
            failures++; $display("FAIL reset_last got=%h/%b exp=0/0", last_rk, last_rk_valid);
        end
`endif
        @(negedge clk); rst = 1'b1; rk_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL idle_after_reset cyc=%0d valid=%b busy=%b exp=0/0", c, rk_valid, busy);
            end
        end
    endtask

    task automatic test_fips_stream();
        int n_acc = 0, n_done = 0, done_at = -1, first_vld = -1;
        @(negedge clk); key = FIPS_KEY; ld = 1'b1; rk_ready = 1'b1; #1;
        checks++; if (rk_valid !== 1'b0) begin failures++; $display("FAIL fips_ld_cycle_valid got=%b exp=0", rk_valid); end
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk); ld = 1'b0; #1;
            if (rk_valid && first_vld < 0) first_vld = c;
            if (rk_valid && rk_ready) begin
                checks++;
                if (n_acc > 10) begin
                    failures++; $display("FAIL fips_extra_key idx=%0d", rk_idx);
                end else if (rk_idx !== 4'(n_acc) || rk !== fips_rk[n_acc]) begin
                    failures++; $display("FAIL fips_key n=%0d got idx=%0d rk=%h exp idx=%0d rk=%h", n_acc, rk_idx, rk, n_acc, fips_rk[n_acc]);
                end
                n_acc++;
            end
            if (done) begin n_done++; done_at = c; end
        end
        checks++; if (first_vld != 1) begin failures++; $display("FAIL fips_first_valid got=%0d exp=1", first_vld); end
        checks++; if (n_acc != 11)    begin failures++; $display("FAIL fips_key_count got=%0d exp=11", n_acc); end
        checks++; if (n_done != 1)    begin failures++; $display("FAIL fips_done_count got=%0d exp=1", n_done); end
        checks++; if (done_at != 22)  begin failures++; $display("FAIL fips_done_cycle got=%0d exp=22", done_at); end
        checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL fips_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_stalls();
        int n_acc = 0, n_done = 0, stall = 0;
        logic held = 1'b0;
        logic [127:0] h_rk = '0;
        logic [3:0]   h_idx = '0;
        @(negedge clk); key = FIPS_KEY; ld = 1'b1; rk_ready = 1'b0; #1;
        stall = $urandom_range(0, 5);
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk); ld = 1'b0; rk_ready = (stall == 0); #1;
            if (held) begin
                checks++; if (rk_valid !== 1'b1 || rk !== h_rk || rk_idx !== h_idx) begin
                    failures++; $display("FAIL stall_hold cyc=%0d got v=%b idx=%0d rk=%h exp v=1 idx=%0d rk=%h", c, rk_valid, rk_idx, rk, h_idx, h_rk);
                end
            end
            held = 1'b0;
            if (rk_valid && rk_ready) begin
                checks++;
                if (n_acc > 10) begin
                    failures++; $display("FAIL stall_extra_key idx=%0d", rk_idx);
                end else if (rk_idx !== 4'(n_acc) || rk !== fips_rk[n_acc]) begin
                    failures++; $display("FAIL stall_key n=%0d got idx=%0d rk=%h exp idx=%0d rk=%h", n_acc, rk_idx, rk, n_acc, fips_rk[n_acc]);
                end
                n_acc++;
                stall = $urandom_range(0, 5);
            end else if (rk_valid) begin
                held = 1'b1; h_rk = rk; h_idx = rk_idx;
                stall--;
            end
            if (done) n_done++;
        end
        checks++; if (n_acc != 11) begin failures++; $display("FAIL stall_key_count got=%0d exp=11", n_acc); end
        checks++; if (n_done != 1) begin failures++; $display("FAIL stall_done_count got=%0d exp=1", n_done); end
    endtask

    task automatic test_restart();
        int n_acc = 0, n_done = 0, done_at = -1;
        @(negedge clk); key = FIPS_KEY; ld = 1'b1; rk_ready = 1'b1; #1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); ld = 1'b0; #1;
            if (rk_valid && rk_ready) n_acc++;
        end
        checks++; if (n_acc != 5) begin failures++; $display("FAIL restart_pre_accepts got=%0d exp=5", n_acc); end
        @(negedge clk); key = '0; ld = 1'b1; #1;
        checks++; if (rk_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL restart_ld_cycle got v=%b busy=%b exp v=0 busy=1", rk_valid, busy);
        end
        n_acc = 0;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk); ld = 1'b0; #1;
            if (rk_valid && rk_ready) begin
                checks++; if (rk_idx !== 4'(n_acc)) begin failures++; $display("FAIL restart_idx got=%0d exp=%0d", rk_idx, n_acc); end
                if (n_acc == 0) begin checks++; if (rk !== 128'h0) begin failures++; $display("FAIL restart_rk0 got=%h exp=0", rk); end end
                if (n_acc == 1) begin checks++; if (rk !== ZK_RK1) begin failures++; $display("FAIL restart_rk1 got=%h exp=%h", rk, ZK_RK1); end end
                if (n_acc == 2) begin checks++; if (rk !== ZK_RK2) begin failures++; $display("FAIL restart_rk2 got=%h exp=%h", rk, ZK_RK2); end end
                n_acc++;
            end
            if (done) begin n_done++; done_at = c; end
        end
        checks++; if (n_acc != 11)   begin failures++; $display("FAIL restart_key_count got=%0d exp=11", n_acc); end
        checks++; if (n_done != 1 || done_at != 22) begin
            failures++; $display("FAIL restart_done got count=%0d at=%0d exp count=1 at=22", n_done, done_at);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); key = FIPS_KEY; ld = 1'b1; rk_ready = 1'b1; #1;
        @(negedge clk); ld = 1'b0; #1;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b1 || rk_valid !== 1'b0 || rk !== FIPS_KEY) begin
            failures++; $display("FAIL arst_pre_step got busy=%b v=%b rk=%h exp busy=1 v=0 rk=%h", busy, rk_valid, rk, FIPS_KEY);
        end
        #2; rst = 1'b0; #1;
        checks++; if (rk !== 128'h0 || rk_idx !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL arst_outputs got rk=%h idx=%0d v=%b busy=%b done=%b exp all 0", rk, rk_idx, rk_valid, busy, done);
        end
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL arst_idle cyc=%0d got v=%b busy=%b exp 0/0", c, rk_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); key = FIPS_KEY; ld = 1'b1; rk_ready = 1'b1; #1;
        for (int c = 1; c <= 20; c++) begin @(negedge clk); ld = 1'b0; #1; end
        @(negedge clk); key = '0; ld = 1'b1; #1;
        checks++; if (rk_idx !== 4'd10 || rk !== fips_rk[10] || rk_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_ld_cycle got idx=%0d v=%b rk=%h exp idx=10 v=0 rk=%h", rk_idx, rk_valid, rk, fips_rk[10]);
        end
        @(negedge clk); ld = 1'b0; #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_no_done got=%b exp=0", done); end
        checks++; if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk !== 128'h0) begin
            failures++; $display("FAIL b2b_restart got v=%b idx=%0d rk=%h exp v=1 idx=0 rk=0", rk_valid, rk_idx, rk);
        end
        @(negedge clk); #1;
        checks++; if (done !== 1'b0 || rk_valid !== 1'b0) begin failures++; $display("FAIL b2b_step got done=%b v=%b exp 0/0", done, rk_valid); end
        @(negedge clk); #1;
        checks++; if (rk_valid !== 1'b1 || rk_idx !== 4'd1 || rk !== ZK_RK1) begin
            failures++; $display("FAIL b2b_rk1 got v=%b idx=%0d rk=%h exp v=1 idx=1 rk=%h", rk_valid, rk_idx, rk, ZK_RK1);
        end
    endtask

`ifdef AES_KS_LAST_KEY_EN
    task automatic test_last_key();
        @(negedge clk); key = FIPS_KEY; ld = 1'b1; rk_ready = 1'b1; #1;
        for (int c = 1; c <= 21; c++) begin @(negedge clk); ld = 1'b0; #1; end
        checks++; if (last_rk_valid !== 1'b0) begin failures++; $display("FAIL last_before got=%b exp=0", last_rk_valid); end
        @(negedge clk); #1;
        checks++; if (last_rk_valid !== 1'b1 || last_rk !== fips_rk[10]) begin
            failures++; $display("FAIL last_after got v=%b rk=%h exp v=1 rk=%h", last_rk_valid, last_rk, fips_rk[10]);
        end
        @(negedge clk); ld = 1'b1; #1;
        @(negedge clk); ld = 1'b0; #1;
        checks++; if (last_rk_valid !== 1'b0) begin failures++; $display("FAIL last_cleared got=%b exp=0", last_rk_valid); end
    endtask
`endif

    initial begin
        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
        fips_rk[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
        fips_rk[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
        fips_rk[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
        fips_rk[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
        fips_rk[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
        fips_rk[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
        fips_rk[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
        fips_rk[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
        fips_rk[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

        test_reset();
        test_fips_stream();
        test_stalls();
        test_restart();
        test_async_reset();
        test_back_to_back();
`ifdef AES_KS_LAST_KEY_EN
        test_last_key();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
